// File: rtl/cdb_arbiter.sv
// Writeback arbiter: three per-producer result FIFOs drained round-robin onto
// a single registered (num, value) broadcast bus. Tag 0 means "no result".
module cdb_arbiter #(
    parameter int unsigned DEPTH  = 2,
    parameter int unsigned TAG_W  = 3,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,

    input  logic              req0_valid,
    input  logic [TAG_W-1:0]  req0_tag,
    input  logic [DATA_W-1:0] req0_value,
    output logic              req0_ready,

    input  logic              req1_valid,
    input  logic [TAG_W-1:0]  req1_tag,
    input  logic [DATA_W-1:0] req1_value,
    output logic              req1_ready,

    input  logic              req2_valid,
    input  logic [TAG_W-1:0]  req2_tag,
    input  logic [DATA_W-1:0] req2_value,
    output logic              req2_ready,

    output logic [TAG_W-1:0]  cdb_num,
    output logic [DATA_W-1:0] cdb_value,
    output logic [3:0]        pending
);

    localparam int unsigned NP    = 3;
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [TAG_W-1:0]  tag_mem_q [NP][DEPTH];
    logic [DATA_W-1:0] val_mem_q [NP][DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q  [NP];
    logic [PTR_W-1:0]  rd_ptr_q  [NP];
    logic [CNT_W-1:0]  count_q   [NP];
    logic [CNT_W-1:0]  count_d   [NP];

    logic [1:0]        rr_ptr_q, rr_ptr_d;
    logic [TAG_W-1:0]  cdb_num_q, cdb_num_d;
    logic [DATA_W-1:0] cdb_value_q, cdb_value_d;
    logic [3:0]        pending_q, pending_d;

    logic              in_valid [NP];
    logic [TAG_W-1:0]  in_tag   [NP];
    logic [DATA_W-1:0] in_value [NP];
    logic              ready    [NP];
    logic              push     [NP];
    logic              pop      [NP];

    logic              grant_valid;
    logic [1:0]        grant_idx;
    logic [2:0]        cand_sum;
    logic [1:0]        cand;

    always_comb begin
        in_valid[0] = req0_valid;
        in_tag[0]   = req0_tag;
        in_value[0] = req0_value;
        in_valid[1] = req1_valid;
        in_tag[1]   = req1_tag;
        in_value[1] = req1_value;
        in_valid[2] = req2_valid;
        in_tag[2]   = req2_tag;
        in_value[2] = req2_value;
    end

    // Readiness looks only at the registered count; a same-cycle pop does not free a slot.
    always_comb begin
        for (int unsigned i = 0; i < NP; i++) begin
            ready[i] = (count_q[i] < CNT_W'(DEPTH)) && !flush && !rst;
            push[i]  = in_valid[i] && ready[i] && (in_tag[i] != '0);
        end
    end

    assign req0_ready = ready[0];
    assign req1_ready = ready[1];
    assign req2_ready = ready[2];

    // Round-robin search starting at rr_ptr_q, modulo 3.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand_sum    = '0;
        cand        = '0;
        for (int unsigned k = 0; k < NP; k++) begin
            cand_sum = {1'b0, rr_ptr_q} + 3'(k);
            cand     = (cand_sum >= 3'd3) ? 2'(cand_sum - 3'd3) : cand_sum[1:0];
            if (!grant_valid && (count_q[cand] != '0)) begin
                grant_valid = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    always_comb begin
        pending_d   = '0;
        cdb_num_d   = '0;
        cdb_value_d = '0;
        rr_ptr_d    = rr_ptr_q;
        for (int unsigned i = 0; i < NP; i++) begin
            pop[i]     = grant_valid && (grant_idx == 2'(i));
            count_d[i] = count_q[i] + CNT_W'(push[i]) - CNT_W'(pop[i]);
            pending_d  = pending_d + 4'(count_d[i]);
        end
        if (grant_valid) begin
            cdb_num_d   = tag_mem_q[grant_idx][rd_ptr_q[grant_idx]];
            cdb_value_d = val_mem_q[grant_idx][rd_ptr_q[grant_idx]];
            rr_ptr_d    = (grant_idx == 2'd2) ? 2'd0 : grant_idx + 2'd1;
        end
    end

    // Storage needs no reset: push is held off during rst/flush and occupancy lives in count_q.
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < NP; i++) begin
            if (push[i]) begin
                tag_mem_q[i][wr_ptr_q[i]] <= in_tag[i];
                val_mem_q[i][wr_ptr_q[i]] <= in_value[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            for (int unsigned i = 0; i < NP; i++) begin
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
                count_q[i]  <= '0;
            end
            rr_ptr_q    <= '0;
            cdb_num_q   <= '0;
            cdb_value_q <= '0;
            pending_q   <= '0;
        end else begin
            for (int unsigned i = 0; i < NP; i++) begin
                if (push[i]) begin
                    wr_ptr_q[i] <= wr_ptr_q[i] + 1'b1;
                end
                if (pop[i]) begin
                    rd_ptr_q[i] <= rd_ptr_q[i] + 1'b1;
                end
                count_q[i] <= count_d[i];
            end
            rr_ptr_q    <= rr_ptr_d;
            cdb_num_q   <= cdb_num_d;
            cdb_value_q <= cdb_value_d;
            pending_q   <= pending_d;
        end
    end

    assign cdb_num   = cdb_num_q;
    assign cdb_value = cdb_value_q;
    assign pending   = pending_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: reset, latency, round-robin order,
// backpressure, flush and zero-tag handling with hand-computed expectations.
module tb_cdb_arbiter;

    localparam int unsigned DEPTH  = 2;
    localparam int unsigned TAG_W  = 3;
    localparam int unsigned DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              flush;
    logic              req0_valid, req1_valid, req2_valid;
    logic [TAG_W-1:0]  req0_tag, req1_tag, req2_tag;
    logic [DATA_W-1:0] req0_value, req1_value, req2_value;
    logic              req0_ready, req1_ready, req2_ready;
    logic [TAG_W-1:0]  cdb_num;
    logic [DATA_W-1:0] cdb_value;
    logic [3:0]        pending;

    int unsigned n_chk  = 0;
    int unsigned n_fail = 0;

    cdb_arbiter #(
        .DEPTH  (DEPTH),
        .TAG_W  (TAG_W),
        .DATA_W (DATA_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .req0_valid (req0_valid),
        .req0_tag   (req0_tag),
        .req0_value (req0_value),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_tag   (req1_tag),
        .req1_value (req1_value),
        .req1_ready (req1_ready),
        .req2_valid (req2_valid),
        .req2_tag   (req2_tag),
        .req2_value (req2_value),
        .req2_ready (req2_ready),
        .cdb_num    (cdb_num),
        .cdb_value  (cdb_value),
        .pending    (pending)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int p, input logic v, input logic [TAG_W-1:0] t, input logic [DATA_W-1:0] d);
        case (p)
            0: begin req0_valid = v; req0_tag = t; req0_value = d; end
            1: begin req1_valid = v; req1_tag = t; req1_value = d; end
            default: begin req2_valid = v; req2_tag = t; req2_value = d; end
        endcase
    endtask

    task automatic idle_all();
        drive(0, 1'b0, '0, '0);
        drive(1, 1'b0, '0, '0);
        drive(2, 1'b0, '0, '0);
    endtask

    task automatic chk_cdb(input string name, input logic [TAG_W-1:0] num, input logic [DATA_W-1:0] val, input logic [3:0] pend);
        chk({name, ".num"}, 32'(cdb_num), 32'(num));
        chk({name, ".value"}, cdb_value, val);
        chk({name, ".pending"}, 32'(pending), 32'(pend));
    endtask

    initial begin
        // Reset held for two cycles while req0 offers tag 3.
        rst   = 1'b1;
        flush = 1'b0;
        idle_all();
        drive(0, 1'b1, 3'd3, 32'h1234);
        #2;
        chk("rst.ready0", 32'(req0_ready), 32'd0);
        tick();
        chk_cdb("rst.c1", 3'd0, 32'h0, 4'd0);
        chk("rst.ready0_c1", 32'(req0_ready), 32'd0);
        tick();
        chk_cdb("rst.c2", 3'd0, 32'h0, 4'd0);
        rst = 1'b0;
        idle_all();
        tick();
        chk_cdb("rst.after", 3'd0, 32'h0, 4'd0);

        // Zero tag accepted but never stored.
        drive(0, 1'b1, 3'd0, 32'h55);
        #1;
        chk("zt.ready0", 32'(req0_ready), 32'd1);
        tick();
        chk_cdb("zt.c1", 3'd0, 32'h0, 4'd0);
        idle_all();
        tick();
        chk_cdb("zt.c2", 3'd0, 32'h0, 4'd0);

        // Single producer: broadcast one cycle after acceptance, held one cycle.
        drive(1, 1'b1, 3'd5, 32'hDEADBEEF);
        tick();
        chk_cdb("lat.accept", 3'd0, 32'h0, 4'd1);
        idle_all();
        tick();
        chk_cdb("lat.bcast", 3'd5, 32'hDEADBEEF, 4'd0);
        tick();
        chk_cdb("lat.idle", 3'd0, 32'h0, 4'd0);

        // Bring rr_ptr back to 0.
        rst = 1'b1;
        tick();
        rst = 1'b0;

        // Round-robin: two simultaneous batches.
        drive(0, 1'b1, 3'd1, 32'h11);
        drive(1, 1'b1, 3'd2, 32'h22);
        drive(2, 1'b1, 3'd3, 32'h33);
        tick();
        chk_cdb("rr.push1", 3'd0, 32'h0, 4'd3);
        idle_all();
        tick();
        chk_cdb("rr.b1", 3'd1, 32'h11, 4'd2);
        tick();
        chk_cdb("rr.b2", 3'd2, 32'h22, 4'd1);
        tick();
        chk_cdb("rr.b3", 3'd3, 32'h33, 4'd0);
        drive(0, 1'b1, 3'd4, 32'h44);
        drive(1, 1'b1, 3'd5, 32'h55);
        drive(2, 1'b1, 3'd6, 32'h66);
        tick();
        chk_cdb("rr.push2", 3'd0, 32'h0, 4'd3);
        idle_all();
        tick();
        chk_cdb("rr.b4", 3'd4, 32'h44, 4'd2);
        tick();
        chk_cdb("rr.b5", 3'd5, 32'h55, 4'd1);
        tick();
        chk_cdb("rr.b6", 3'd6, 32'h66, 4'd0);

        // Backpressure on req2 with req0 competing ahead of it.
        drive(0, 1'b1, 3'd7, 32'h70);
        drive(2, 1'b1, 3'd1, 32'hA1);
        tick();
        chk_cdb("bp.e1", 3'd0, 32'h0, 4'd2);
        drive(0, 1'b1, 3'd6, 32'h60);
        drive(2, 1'b1, 3'd2, 32'hA2);
        #1;
        chk("bp.ready2_c1", 32'(req2_ready), 32'd1);
        tick();
        chk_cdb("bp.e2", 3'd7, 32'h70, 4'd3);
        drive(0, 1'b0, '0, '0);
        drive(2, 1'b1, 3'd3, 32'hA3);
        #1;
        chk("bp.ready2_full", 32'(req2_ready), 32'd0);
        tick();
        chk_cdb("bp.e3", 3'd1, 32'hA1, 4'd2);
        chk("bp.ready2_freed", 32'(req2_ready), 32'd1);
        tick();
        chk_cdb("bp.e4", 3'd6, 32'h60, 4'd2);
        idle_all();
        tick();
        chk_cdb("bp.e5", 3'd2, 32'hA2, 4'd1);
        tick();
        chk_cdb("bp.e6", 3'd3, 32'hA3, 4'd0);
        tick();
        chk_cdb("bp.e7", 3'd0, 32'h0, 4'd0);

        // Flush with four entries queued while req0 offers tag 7.
        drive(0, 1'b1, 3'd1, 32'h01);
        drive(1, 1'b1, 3'd2, 32'h02);
        drive(2, 1'b1, 3'd3, 32'h03);
        tick();
        chk_cdb("fl.e1", 3'd0, 32'h0, 4'd3);
        drive(0, 1'b1, 3'd4, 32'h04);
        drive(1, 1'b1, 3'd5, 32'h05);
        drive(2, 1'b0, '0, '0);
        tick();
        chk_cdb("fl.e2", 3'd1, 32'h01, 4'd4);
        flush = 1'b1;
        drive(0, 1'b1, 3'd7, 32'h77);
        drive(1, 1'b0, '0, '0);
        #1;
        chk("fl.ready0", 32'(req0_ready), 32'd0);
        tick();
        chk_cdb("fl.e3", 3'd0, 32'h0, 4'd0);
        flush = 1'b0;
        idle_all();
        #1;
        chk("fl.ready0_after", 32'(req0_ready), 32'd1);
        tick();
        chk_cdb("fl.e4", 3'd0, 32'h0, 4'd0);
        tick();
        chk_cdb("fl.e5", 3'd0, 32'h0, 4'd0);

        // Reset mid-operation discards a queued result.
        drive(1, 1'b1, 3'd4, 32'h4444);
        tick();
        chk_cdb("mr.push", 3'd0, 32'h0, 4'd1);
        idle_all();
        rst = 1'b1;
        tick();
        chk_cdb("mr.rst", 3'd0, 32'h0, 4'd0);
        rst = 1'b0;
        tick();
        chk_cdb("mr.after", 3'd0, 32'h0, 4'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Arbitrates result writeback from three execution producers onto the single ROB writeback bus: ALU0, ALU1 and the load/store unit.
- Each producer gets a small FIFO. One result per cycle is granted round-robin and driven as a registered (num, value) pair.
- Downstream, cdb_num/cdb_value feed the ROB result port (tag 0 = no result), so producers never collide on the ROB result write.

Parameters:
- DEPTH, 2, entries per producer FIFO (power of two, >= 2).
- TAG_W, 3, ROB index width; tag 0 is reserved as "no entry".
- DATA_W, 32, result value width.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  reset, synchronous, active-high.
- flush  input  1  misprediction/JALR squash; clears all pending results.
- req0_valid  input  1  ALU0 result valid.
- req0_tag  input  TAG_W  ALU0 ROB index.
- req0_value  input  DATA_W  ALU0 result.
- req0_ready  output  1  ALU0 FIFO can accept.
- req1_valid / req1_tag / req1_value / req1_ready  same for ALU1.
- req2_valid / req2_tag / req2_value / req2_ready  same for load/store unit.
- cdb_num  output  TAG_W  broadcast ROB index, 0 = idle.
- cdb_value  output  DATA_W  broadcast value.
- pending  output  4  total queued entries across all FIFOs.

Behaviour:
- Reset (rst=1 at edge): all FIFOs empty, rr_ptr=0, cdb_num=0, cdb_value=0, pending=0. Reset overrides flush and all requests. Reset mid-operation discards queued results with no broadcast.
- Readiness: reqN_ready = (countN < DEPTH) && !flush && !rst. It is combinational from registered count only; a pop in the same cycle does not free a slot for that cycle.
- Enqueue: on valid && ready, push {tag, value}.
- Zero tag: valid with tag == 0 is accepted (ready honoured) but not stored.
- Valid while not ready: the producer must hold tag/value stable. Nothing is lost inside this block.
- Eligibility: only entries present before the edge are eligible. An input accepted at edge t is broadcast no earlier than the output registered at edge t+1, so minimum latency is 1 cycle after acceptance.
- Grant: among non-empty FIFOs, search from index rr_ptr upward modulo 3. The first found is popped, its head is driven to cdb_num/cdb_value at the edge, and rr_ptr <= (granted + 1) mod 3. With no non-empty FIFO: cdb_num <= 0, cdb_value <= 0, rr_ptr unchanged.
- Throughput: exactly one grant per cycle; the output is held only one cycle (no hold on idle).
- Push and pop on the same FIFO in the same cycle: count unchanged, ordering preserved (FIFO order within a producer always holds).
- FIFO pointers wrap modulo DEPTH. Full is count == DEPTH and empty is count == 0; no pointer-equality ambiguity.
- Flush (flush=1 at edge, rst=0): all FIFOs emptied, cdb_num <= 0, cdb_value <= 0, rr_ptr <= 0. Inputs offered that cycle are not accepted (ready low).
- pending: registered sum of the three counts after the edge's push/pop. It saturates naturally at 3*DEPTH (<= 15 for DEPTH <= 5; DEPTH=2 gives max 6).
- No combinational path from reqN_valid to cdb_*; cdb_* are pure flops.

Test Plan:
- Reset: rst=1 for 2 cycles with req0_valid=1, tag=3 -> cdb_num=0, pending=0, req0_ready=0 during reset, and no broadcast of tag 3 afterward.
- Single producer latency: req1 tag=5 value=0xDEADBEEF accepted at edge t -> cdb_num=5 and cdb_value=0xDEADBEEF after edge t+1, then cdb_num=0 after edge t+2.
- Round-robin: all three push simultaneously (tags 1, 2, 3, values 0x11, 0x22, 0x33) with rr_ptr=0 -> broadcasts in consecutive cycles are 1, 2, 3. A second simultaneous batch (tags 4, 5, 6) -> 4, 5, 6 (rr_ptr back at 0).
- Full/backpressure: DEPTH=2, req2 pushes tags 1, 2, 3 back-to-back while req0 keeps its FIFO non-empty ahead in priority. Required: req2_ready drops once count=2, tag 3 is held by the producer, and order 1, 2, 3 is preserved on cdb_num with no loss.
- Flush: with 4 entries pending, assert flush one cycle while req0_valid=1 tag=7 -> next cycle cdb_num=0 and pending=0, tag 7 is never broadcast, and req0_ready=0 during the flush cycle.
- Zero tag: req0_valid=1, tag=0, value=0x55 -> req0_ready=1, pending stays 0, cdb_num stays 0.
